serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal: 2..64).
REQ-002 The block SHALL have parameter DIGIT, default 1, bits added per cycle (legal: 1..WIDTH; WIDTH mod DIGIT = 0).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request to begin an operation.
REQ-006 The block SHALL have port a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-007 The block SHALL have port b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-008 The block SHALL have port c  input  1  carry-in, sampled only when start is accepted, ignored when sub=1.
REQ-009 The block SHALL have port sub  input  1  mode: 0 = add, 1 = subtract, sampled only when start is accepted.
REQ-010 The block SHALL have port busy  output  1  high while digits are being processed.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-012 The block SHALL have port sum  output  WIDTH  result.
REQ-013 The block SHALL have port cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
REQ-014 The block SHALL have port ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-016 A start is accepted when start=1 at a rising edge in IDLE or DONE; the edge latches a, b (inverted if sub=1), and carry = (sub ? 1 : c), clears the digit counter, and enters RUN.
REQ-017 In RUN, each rising edge SHALL add digit k (bits k*DIGIT..k*DIGIT+DIGIT-1, LSB-first) of the latched operands plus the registered carry, write the result digit into sum, update the carry register and increment k.
REQ-018 On the edge processing digit N-1, the block SHALL move to DONE, set cout = final carry, and set ovf = (carry into MSB) XOR (carry out of MSB).
REQ-019 Latency: start accepted at edge t -> busy=1 in cycles t+1..t+N, done=1 and busy=0 in the single cycle after edge t+N.
REQ-020 In DONE without start, the next edge SHALL return to IDLE; sum, cout, ovf SHALL hold until the next accepted start.
REQ-021 start in DONE SHALL be accepted (back-to-back operations, no idle gap); done still pulses for exactly one cycle.
REQ-022 start while in RUN SHALL be ignored with no effect on the operation in progress; changes to a, b, c, sub during RUN SHALL have no effect.
REQ-023 Results SHALL be exact modulo 2^WIDTH: add = a+b+c, sub = a-b; cout = bit WIDTH of the full-width sum.
REQ-024 sum SHALL be undefined-free at all times (partial digits visible during RUN are permitted; only values at done are specified).
REQ-025 The case DIGIT=WIDTH SHALL work with N=1 (one RUN cycle).

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry=0, counter=0, taking priority over start.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no done pulse is produced for it.
REQ-028 The first start accepted after rst deasserts SHALL behave identically to a start after power-up reset.

Verification
REQ-029 WIDTH=8, DIGIT=1: a=8'h0F, b=8'h01, c=0, sub=0 -> done exactly 9 edges after the start edge, sum=8'h10, cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-030 WIDTH=8, DIGIT=2: a=8'hFF, b=8'h00, c=1, sub=0 -> sum=8'h00, cout=1, ovf=0, done 5 edges after start; a=8'h7F, b=8'h01, c=0 -> sum=8'h80, ovf=1, cout=0.
REQ-031 WIDTH=8, DIGIT=4, sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0; a=8'h80, b=8'h01 -> sum=8'h7F, ovf=1, cout=1.
REQ-032 Back-to-back: start held high continuously with new operands each DONE cycle -> one done pulse per operation, every result correct, no IDLE cycle between operations.
REQ-033 Interference: toggle start, a, b, c, sub every cycle during RUN -> result equals the operands latched at the accepted start.
REQ-034 Reset mid-RUN at digit 3 of 8 -> next cycle busy=0, done=0, all outputs 0; a following start of 8'h01+8'h01 yields sum=8'h02 with normal latency.
REQ-035 Exhaustive: WIDTH=4 with DIGIT in {1,2,4}, all a, b, c, sub combinations -> sum, cout, ovf match a reference model for every operation.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB first,
// and reports sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [DIGIT-1:0]   a_dig, b_dig;
   logic [DIGIT:0]     dsum;
   logic               msb_cin;
   int                 lsb;

   // Current digit slice and its DIGIT-bit add with the registered carry.
   always_comb begin
      lsb     = int'(k_q) * DIGIT;
      a_dig   = a_q[lsb +: DIGIT];
      b_dig   = b_q[lsb +: DIGIT];
      dsum    = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT + 1)'(carry_q);
      // Carry into the top bit of this digit, recovered from its sum bit.
      msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1];
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the branches below can leave one unassigned and infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      if (start && state_q != RUN) begin
         // Subtraction is a + ~b + 1, so the operand is inverted at load time.
         state_d = RUN;
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub | c;
         k_d     = '0;
         sum_d   = '0;
         cout_d  = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               sum_d[lsb +: DIGIT] = dsum[DIGIT-1:0];
               carry_d             = dsum[DIGIT];
               if (k_q == CNT_W'(N - 1)) begin
                  state_d = DONE;
                  k_d     = '0;
                  cout_d  = dsum[DIGIT];
                  ovf_d   = msb_cin ^ dsum[DIGIT];
               end else begin
                  k_d = k_q + CNT_W'(1);
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder across several WIDTH/DIGIT
// configurations sharing one clock and reset.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // WIDTH=8 instances: index 0 -> DIGIT 1, 1 -> DIGIT 2, 2 -> DIGIT 4.
   logic       start8 [3];
   logic [7:0] a8, b8;
   logic       c8, sub8;
   logic       busy8 [3], done8 [3], cout8 [3], ovf8 [3];
   logic [7:0] sum8 [3];
   int         n8 [3] = '{8, 4, 2};

   // WIDTH=4 instances share one start: index 0 -> DIGIT 1, 1 -> 2, 2 -> 4.
   logic       start4;
   logic [3:0] a4, b4;
   logic       c4, sub4;
   logic       busy4 [3], done4 [3], cout4 [3], ovf4 [3];
   logic [3:0] sum4 [3];
   int         n4 [3] = '{4, 2, 1};

   serial_adder #(.WIDTH(8), .DIGIT(1)) u8_d1 (.clk(clk), .rst(rst), .start(start8[0]),
      .a(a8), .b(b8), .c(c8), .sub(sub8), .busy(busy8[0]), .done(done8[0]),
      .sum(sum8[0]), .cout(cout8[0]), .ovf(ovf8[0]));
   serial_adder #(.WIDTH(8), .DIGIT(2)) u8_d2 (.clk(clk), .rst(rst), .start(start8[1]),
      .a(a8), .b(b8), .c(c8), .sub(sub8), .busy(busy8[1]), .done(done8[1]),
      .sum(sum8[1]), .cout(cout8[1]), .ovf(ovf8[1]));
   serial_adder #(.WIDTH(8), .DIGIT(4)) u8_d4 (.clk(clk), .rst(rst), .start(start8[2]),
      .a(a8), .b(b8), .c(c8), .sub(sub8), .busy(busy8[2]), .done(done8[2]),
      .sum(sum8[2]), .cout(cout8[2]), .ovf(ovf8[2]));

   serial_adder #(.WIDTH(4), .DIGIT(1)) u4_d1 (.clk(clk), .rst(rst), .start(start4),
      .a(a4), .b(b4), .c(c4), .sub(sub4), .busy(busy4[0]), .done(done4[0]),
      .sum(sum4[0]), .cout(cout4[0]), .ovf(ovf4[0]));
   serial_adder #(.WIDTH(4), .DIGIT(2)) u4_d2 (.clk(clk), .rst(rst), .start(start4),
      .a(a4), .b(b4), .c(c4), .sub(sub4), .busy(busy4[1]), .done(done4[1]),
      .sum(sum4[1]), .cout(cout4[1]), .ovf(ovf4[1]));
   serial_adder #(.WIDTH(4), .DIGIT(4)) u4_d4 (.clk(clk), .rst(rst), .start(start4),
      .a(a4), .b(b4), .c(c4), .sub(sub4), .busy(busy4[2]), .done(done4[2]),
      .sum(sum4[2]), .cout(cout4[2]), .ovf(ovf4[2]));

   // One operation on 8-bit instance s; checks latency, busy length and result.
   task automatic op8(input int s, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic tc, input logic tsub, input logic [7:0] es,
                      input logic ec, input logic eo, input string tag);
      int lat = 0;
      int busy_cnt = 0;
      @(negedge clk);
      a8 = ta; b8 = tb_v; c8 = tc; sub8 = tsub; start8[s] = 1'b1;
      @(posedge clk);
      #1 start8[s] = 1'b0;
      for (int i = 1; i <= n8[s] + 4; i++) begin
         @(negedge clk);
         if (done8[s]) begin
            lat = i;
            break;
         end
         if (busy8[s]) busy_cnt++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(n8[s] + 1));
      check({tag, "_busy"}, 64'(busy_cnt), 64'(n8[s]));
      check({tag, "_res"}, {54'd0, busy8[s], cout8[s], ovf8[s], sum8[s]}, {54'd0, 1'b0, ec, eo, es});
   endtask

   logic [7:0] bb_a [4] = '{8'h01, 8'hFF, 8'h80, 8'h12};
   logic [7:0] bb_b [4] = '{8'h02, 8'h01, 8'h80, 8'h34};
   logic       bb_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic       bb_s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic [9:0] bb_e [4] = '{{2'b00, 8'h03}, {2'b10, 8'hFE}, {2'b11, 8'h01}, {2'b00, 8'h47}};

   initial begin
      for (int s = 0; s < 3; s++) start8[s] = 1'b0;
      a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; sub4 = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("reset8_%0d", s), {busy8[s], done8[s], cout8[s], ovf8[s], sum8[s]}, 64'd0);
         check($sformatf("reset4_%0d", s), {busy4[s], done4[s], cout4[s], ovf4[s], sum4[s]}, 64'd0);
      end
      rst = 1'b0;

      op8(0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "d1_0f_01");
      repeat (3) @(negedge clk);
      check("d1_hold", {done8[0], cout8[0], ovf8[0], sum8[0]}, {3'b000, 8'h10});
      op8(0, 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "d1_sub_eq");
      op8(1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "d2_ff_c");
      op8(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "d2_7f_01");
      op8(1, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "d2_40_40");
      op8(2, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "d4_05m07");
      op8(2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "d4_80m01");
      op8(2, 8'hC8, 8'h64, 1'b1, 1'b0, 8'h2D, 1'b1, 1'b0, "d4_c8_64");

      // Back-to-back on DIGIT=2: start held high, new operands each done cycle.
      begin
         int k = 0;
         int last = 0;
         int cyc = 0;
         @(negedge clk);
         a8 = bb_a[0]; b8 = bb_b[0]; c8 = bb_c[0]; sub8 = bb_s[0]; start8[1] = 1'b1;
         while (k < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done8[1]) begin
               check($sformatf("b2b_res_%0d", k), {cout8[1], ovf8[1], sum8[1]}, bb_e[k]);
               check($sformatf("b2b_gap_%0d", k), 64'(cyc - last), 64'd5);
               last = cyc;
               k++;
               if (k < 4) begin
                  a8 = bb_a[k]; b8 = bb_b[k]; c8 = bb_c[k]; sub8 = bb_s[k];
               end else begin
                  start8[1] = 1'b0;
               end
            end
         end
         start8[1] = 1'b0;
         check("b2b_count", 64'(k), 64'd4);
      end

      // Inputs scrambled every cycle while the DIGIT=1 instance is running.
      begin
         int lat = 0;
         @(negedge clk);
         a8 = 8'h3C; b8 = 8'hA5; c8 = 1'b1; sub8 = 1'b0; start8[0] = 1'b1;
         @(posedge clk);
         for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done8[0]) begin
               lat = i;
               start8[0] = 1'b0;
               break;
            end
            {a8, b8} = 16'($urandom);
            {c8, sub8} = 2'($urandom);
            start8[0] = ~start8[0];
         end
         start8[0] = 1'b0;
         check("intf_lat", 64'(lat), 64'd9);
         check("intf_res", {cout8[0], ovf8[0], sum8[0]}, {2'b00, 8'hE2});
         repeat (2) @(negedge clk);
      end

      // Reset while the DIGIT=1 instance is on digit 3.
      begin
         logic seen_done = 1'b0;
         @(negedge clk);
         a8 = 8'h55; b8 = 8'h33; c8 = 1'b0; sub8 = 1'b0; start8[0] = 1'b1;
         @(posedge clk);
         #1 start8[0] = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check("rst_mid", {busy8[0], done8[0], cout8[0], ovf8[0], sum8[0]}, 64'd0);
         rst = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_done = seen_done | done8[0];
         end
         check("rst_no_done", 64'(seen_done), 64'd0);
         op8(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "rst_after");
      end

      // Exhaustive WIDTH=4 sweep against a signed/unsigned reference model.
      for (int sb = 0; sb < 2; sb++) begin
         for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 16; ai++) begin
               for (int bi = 0; bi < 16; bi++) begin
                  logic [3:0] bop;
                  logic       cin;
                  logic [4:0] full;
                  logic       eo;
                  bop  = (sb != 0) ? ~4'(bi) : 4'(bi);
                  cin  = (sb != 0) ? 1'b1 : 1'(ci);
                  full = 5'(ai) + {1'b0, bop} + 5'(cin);
                  eo   = (4'(ai) >> 3 == bop >> 3) && (full[3] != 1'(ai >> 3));
                  @(negedge clk);
                  a4 = 4'(ai); b4 = 4'(bi); c4 = 1'(ci); sub4 = 1'(sb); start4 = 1'b1;
                  @(posedge clk);
                  #1 start4 = 1'b0;
                  for (int cyc = 1; cyc <= 5; cyc++) begin
                     @(negedge clk);
                     for (int s = 0; s < 3; s++) begin
                        if (cyc == n4[s] + 1)
                           check($sformatf("exh_n%0d_a%0h_b%0h_c%0d_s%0d", n4[s], ai, bi, ci, sb),
                                 {done4[s], cout4[s], ovf4[s], sum4[s]},
                                 {1'b1, full[4], eo, full[3:0]});
                     end
                  end
               end
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
